// File: rtl/cpu_defs.sv
// Shared definitions for the CPU memory-access stage.
//   - Access width codes carried on i_width.
//   - Fault cause codes reported on o_fault_cause.
//   - Load/store unit FSM state encoding.
package cpu_defs;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_BUS     = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit (little-endian).
//   addr_lo_i    : byte offset within the word
//   width_i      : access width code
//   signed_i     : sign-extend the load result
//   wdata_i      : right-justified store data
//   rdata_raw_i  : raw 32-bit bus read data
//   misaligned_o : access is misaligned or the width code is reserved
//   sel_o        : byte-lane select
//   wdata_o      : store data replicated across all lanes
//   rdata_o      : extracted and extended load data
module lsu_lane_align
  import cpu_defs::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  width_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic        misaligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_raw_i >> {addr_lo_i, 3'b000};

  always_comb begin
    misaligned_o = 1'b0;
    sel_o        = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = 32'h0;
    case (width_i)
      WIDTH_BYTE: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      WIDTH_HALF: begin
        misaligned_o = addr_lo_i[0];
        sel_o        = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      WIDTH_WORD: begin
        misaligned_o = (addr_lo_i != 2'b00);
        sel_o        = 4'b1111;
        rdata_o      = shifted;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_load_store_unit.sv
// Memory-access stage: one byte/half/word load or store per request over
// pipelined Wishbone, with misalignment, bus-error and timeout faults.
//   clk, reset          : clock, synchronous active-low reset
//   i_enable .. i_signed: request from execute (single-cycle pulse)
//   o_rdata             : extended load result, held until the next good load
//   o_completed/o_fault : one-cycle done pulse and its fault qualifier
//   o_fault_cause       : cause code, valid with o_completed
//   o_busy              : request in flight
//   o_wb_* / i_wb_*     : Wishbone master interface
module wb_load_store_unit
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  output logic [31:0] o_rdata,
  output logic        o_completed,
  output logic        o_busy,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_data,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err
);

  lsu_state_e           state_q, state_d;
  logic [31:2]          addr_q, addr_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic                 we_q, we_d;
  logic [1:0]           width_q, width_d;
  logic                 signed_q, signed_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           cause_q, cause_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  logic                 idle;
  logic [1:0]           al_addr_lo;
  logic [1:0]           al_width;
  logic                 al_signed;
  logic                 al_misaligned;
  logic [3:0]           al_sel;
  logic [31:0]          al_wdata;
  logic [31:0]          al_rdata;
  logic [TIMEOUT_W-1:0] tmo_inc;
  logic                 tmo_hit;

  assign idle = (state_q == StIdle);

  // The aligner checks the incoming request while idle and extracts read data
  // for the latched request otherwise.
  assign al_addr_lo = idle ? i_addr[1:0] : addr_lo_q;
  assign al_width   = idle ? i_width     : width_q;
  assign al_signed  = idle ? i_signed    : signed_q;

  lsu_lane_align u_lane_align (
    .addr_lo_i   (al_addr_lo),
    .width_i     (al_width),
    .signed_i    (al_signed),
    .wdata_i     (i_wdata),
    .rdata_raw_i (i_wb_data),
    .misaligned_o(al_misaligned),
    .sel_o       (al_sel),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  // Counts bus cycles spent in REQ/WAIT; hit fires on the TIMEOUT-th cycle.
  assign tmo_inc = tmo_q + TIMEOUT_W'(1);
  assign tmo_hit = (tmo_inc == TIMEOUT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    addr_lo_d = addr_lo_q;
    we_d      = we_q;
    width_d   = width_q;
    signed_d  = signed_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    cause_d   = cause_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (i_enable) begin
          if (al_misaligned) begin
            cause_d = FAULT_ALIGN;
            state_d = StDone;
          end else begin
            addr_d    = i_addr[31:2];
            addr_lo_d = i_addr[1:0];
            we_d      = i_we;
            width_d   = i_width;
            signed_d  = i_signed;
            sel_d     = al_sel;
            wdata_d   = al_wdata;
            cause_d   = FAULT_NONE;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        tmo_d = tmo_inc;
        if (!i_wb_stall && i_wb_err) begin
          cause_d = FAULT_BUS;
          state_d = StDone;
        end else if (!i_wb_stall && i_wb_ack) begin
          if (!we_q) rdata_d = al_rdata;
          state_d = StDone;
        end else begin
          if (!i_wb_stall) state_d = StWait;
          if (tmo_hit) begin
            cause_d = FAULT_TIMEOUT;
            state_d = StDone;
          end
        end
      end
      StWait: begin
        tmo_d = tmo_inc;
        if (i_wb_err) begin
          cause_d = FAULT_BUS;
          state_d = StDone;
        end else if (i_wb_ack) begin
          if (!we_q) rdata_d = al_rdata;
          state_d = StDone;
        end else if (tmo_hit) begin
          cause_d = FAULT_TIMEOUT;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      addr_lo_q <= '0;
      we_q      <= 1'b0;
      width_q   <= '0;
      signed_q  <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      cause_q   <= FAULT_NONE;
      rdata_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_lo_q <= addr_lo_d;
      we_q      <= we_d;
      width_q   <= width_d;
      signed_q  <= signed_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      cause_q   <= cause_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
    end
  end

  // All outputs decode registered state only.
  assign o_busy        = (state_q != StIdle);
  assign o_wb_cyc      = (state_q == StReq) || (state_q == StWait);
  assign o_wb_stb      = (state_q == StReq);
  assign o_wb_we       = o_wb_cyc & we_q;
  assign o_wb_addr     = {addr_q, 2'b00};
  assign o_wb_sel      = sel_q;
  assign o_wb_data     = wdata_q;
  assign o_completed   = (state_q == StDone);
  assign o_fault       = o_completed && (cause_q != FAULT_NONE);
  assign o_fault_cause = o_completed ? cause_q : FAULT_NONE;
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Bench for wb_load_store_unit: a vector table driven through a zero-wait
// slave, plus hand-written stall, reset and timeout/error sequences.
module tb_wb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, en_t4;
  logic        we;
  logic [31:0] addr, wdata;
  logic [1:0]  width;
  logic        sgn;
  logic [31:0] wb_rd;
  logic        ack, stall, err;

  logic [31:0] rdata, wb_addr, wb_data;
  logic        completed, busy, fault, cyc, stb, wb_we;
  logic [1:0]  cause;
  logic [3:0]  sel;

  logic [31:0] t_rdata, t_wb_addr, t_wb_data;
  logic        t_completed, t_busy, t_fault, t_cyc, t_stb, t_wb_we;
  logic [1:0]  t_cause;
  logic [3:0]  t_sel;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int pulses_ref;

  always #5 clk = ~clk;

  always @(negedge clk) if (completed) pulses++;

  wb_load_store_unit #(.TIMEOUT(255), .TIMEOUT_W(16)) u_dut (
    .clk(clk), .reset(reset), .i_enable(en), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_width(width), .i_signed(sgn), .o_rdata(rdata), .o_completed(completed),
    .o_busy(busy), .o_fault(fault), .o_fault_cause(cause), .o_wb_cyc(cyc), .o_wb_stb(stb),
    .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_sel(sel), .o_wb_data(wb_data),
    .i_wb_data(wb_rd), .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err)
  );

  wb_load_store_unit #(.TIMEOUT(4), .TIMEOUT_W(16)) u_dut_t4 (
    .clk(clk), .reset(reset), .i_enable(en_t4), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_width(width), .i_signed(sgn), .o_rdata(t_rdata), .o_completed(t_completed),
    .o_busy(t_busy), .o_fault(t_fault), .o_fault_cause(t_cause), .o_wb_cyc(t_cyc),
    .o_wb_stb(t_stb), .o_wb_we(t_wb_we), .o_wb_addr(t_wb_addr), .o_wb_sel(t_sel),
    .o_wb_data(t_wb_data), .i_wb_data(wb_rd), .i_wb_ack(ack), .i_wb_stall(stall),
    .i_wb_err(err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] bus;
    logic [3:0]  sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] wd, input logic s);
    we = w; addr = a; wdata = d; width = wd; sgn = s;
  endtask

  initial begin
    // we, addr, wdata, width, sgn, bus data, sel, exp wdata, exp rdata, cause
    vecs[0]  = '{1'b0, 32'hb000_0010, 32'h0, 2'b10, 1'b0, 32'hdead_beef, 4'b1111, 32'h0,
                 32'hdead_beef, 2'b00};
    vecs[1]  = '{1'b0, 32'hb000_0013, 32'h0, 2'b00, 1'b1, 32'h80aa_bbcc, 4'b1000, 32'h0,
                 32'hffff_ff80, 2'b00};
    vecs[2]  = '{1'b0, 32'hb000_0013, 32'h0, 2'b00, 1'b0, 32'h80aa_bbcc, 4'b1000, 32'h0,
                 32'h0000_0080, 2'b00};
    vecs[3]  = '{1'b0, 32'hb000_0002, 32'h0, 2'b01, 1'b1, 32'h80aa_bbcc, 4'b1100, 32'h0,
                 32'hffff_80aa, 2'b00};
    vecs[4]  = '{1'b0, 32'hb000_0000, 32'h0, 2'b01, 1'b0, 32'h80aa_bbcc, 4'b0011, 32'h0,
                 32'h0000_bbcc, 2'b00};
    vecs[5]  = '{1'b0, 32'hb000_0001, 32'h0, 2'b00, 1'b0, 32'h80aa_bbcc, 4'b0010, 32'h0,
                 32'h0000_00bb, 2'b00};
    vecs[6]  = '{1'b1, 32'h1000_0001, 32'hffff_ff5a, 2'b00, 1'b0, 32'h1111_1111, 4'b0010,
                 32'h5a5a_5a5a, 32'h0000_00bb, 2'b00};
    vecs[7]  = '{1'b1, 32'h1000_0004, 32'hcafe_f00d, 2'b10, 1'b0, 32'h2222_2222, 4'b1111,
                 32'hcafe_f00d, 32'h0000_00bb, 2'b00};
    vecs[8]  = '{1'b0, 32'hb000_0002, 32'h0, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h0,
                 32'h0000_00bb, 2'b01};
    vecs[9]  = '{1'b0, 32'hb000_0000, 32'h0, 2'b11, 1'b0, 32'h0, 4'b0000, 32'h0,
                 32'h0000_00bb, 2'b01};
    vecs[10] = '{1'b1, 32'hb000_0003, 32'h0, 2'b01, 1'b0, 32'h0, 4'b0000, 32'h0,
                 32'h0000_00bb, 2'b01};
    vecs[11] = '{1'b0, 32'hb000_0000, 32'h0, 2'b00, 1'b1, 32'h0000_007f, 4'b0001, 32'h0,
                 32'h0000_007f, 2'b00};

    reset = 1'b0; en = 1'b0; en_t4 = 1'b0;
    drive_req(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    wb_rd = 32'h0; ack = 1'b0; stall = 1'b0; err = 1'b0;
    repeat (3) step();

    // Reset values.
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_completed", completed, 0);
    chk("rst_fault", {fault, cause}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sel_addr_data", {28'h0, sel} | wb_addr | wb_data, 0);
    reset = 1'b1;
    step();

    // Table: zero-wait slave, ACK in the STB cycle.
    for (int i = 0; i < 12; i++) begin
      drive_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].width, vecs[i].sgn);
      en = 1'b1;
      step();
      en = 1'b0;
      if (vecs[i].cause == 2'b01) begin
        chk($sformatf("v%0d_align_completed", i), completed, 1);
        chk($sformatf("v%0d_align_fault", i), fault, 1);
        chk($sformatf("v%0d_align_cause", i), cause, 2'b01);
        chk($sformatf("v%0d_align_cyc", i), cyc, 0);
        chk($sformatf("v%0d_align_rdata", i), rdata, vecs[i].exp_rdata);
        step();
        chk($sformatf("v%0d_align_idle", i), {cyc, busy, completed}, 0);
      end else begin
        chk($sformatf("v%0d_cyc_stb", i), {cyc, stb}, 2'b11);
        chk($sformatf("v%0d_we", i), wb_we, vecs[i].we);
        chk($sformatf("v%0d_addr", i), wb_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_sel", i), sel, vecs[i].sel);
        chk($sformatf("v%0d_early_done", i), completed, 0);
        if (vecs[i].we) chk($sformatf("v%0d_wdata", i), wb_data, vecs[i].exp_wdata);
        ack = 1'b1; wb_rd = vecs[i].bus;
        step();
        ack = 1'b0;
        chk($sformatf("v%0d_completed", i), completed, 1);
        chk($sformatf("v%0d_fault", i), {fault, cause}, 0);
        chk($sformatf("v%0d_cyc_off", i), cyc, 0);
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        step();
        chk($sformatf("v%0d_idle", i), {busy, completed}, 0);
      end
    end

    // Half store with three stall cycles, ACK two cycles after release.
    pulses_ref = pulses;
    drive_req(1'b1, 32'hb000_0002, 32'h0000_1234, 2'b01, 1'b0);
    stall = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_stb", k), {cyc, stb, wb_we}, 3'b111);
      chk($sformatf("stall%0d_sel", k), sel, 4'b1100);
      chk($sformatf("stall%0d_data", k), wb_data, 32'h1234_1234);
      step();
    end
    stall = 1'b0;
    chk("stall_release_stb", stb, 1);
    step();
    chk("stall_wait_cyc_stb", {cyc, stb}, 2'b10);
    step();
    ack = 1'b1;
    chk("stall_wait2_cyc", {cyc, completed}, 2'b10);
    step();
    ack = 1'b0;
    chk("stall_completed", {completed, fault}, 2'b10);
    chk("stall_rdata_kept", rdata, 32'h0000_007f);
    step();
    chk("stall_idle", busy, 0);
    step();
    chk("stall_single_pulse", pulses - pulses_ref, 1);

    // Reset during WAIT, then an immediate fresh request.
    drive_req(1'b0, 32'hb000_0040, 32'h0, 2'b10, 1'b0);
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("rstw_in_wait", {cyc, stb}, 2'b10);
    pulses_ref = pulses;
    reset = 1'b0;
    step();
    chk("rstw_cyc_stb", {cyc, stb}, 0);
    chk("rstw_busy_done", {busy, completed}, 0);
    chk("rstw_rdata", rdata, 0);
    reset = 1'b1;
    drive_req(1'b0, 32'hb000_0043, 32'h0, 2'b00, 1'b0);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("rstw_no_pulse", pulses - pulses_ref, 0);
    chk("rstw_new_req", {cyc, stb}, 2'b11);
    chk("rstw_new_sel", sel, 4'b1000);
    ack = 1'b1; wb_rd = 32'ha500_0000;
    step();
    ack = 1'b0;
    chk("rstw_new_done", {completed, fault}, 2'b10);
    chk("rstw_new_rdata", rdata, 32'h0000_00a5);
    step();

    // TIMEOUT=4 instance: no response, then ERR, then a good load.
    drive_req(1'b0, 32'hb000_0020, 32'h0, 2'b10, 1'b0);
    en_t4 = 1'b1;
    step();
    en_t4 = 1'b0;
    chk("tmo_c1", {t_cyc, t_stb}, 2'b11);
    step();
    step();
    step();
    chk("tmo_c4", {t_cyc, t_completed}, 2'b10);
    step();
    chk("tmo_cyc_drop", t_cyc, 0);
    chk("tmo_done", {t_completed, t_fault, t_cause}, 4'b1111);
    step();
    chk("tmo_idle", t_busy, 0);
    drive_req(1'b0, 32'hb000_0024, 32'h0, 2'b10, 1'b0);
    en_t4 = 1'b1;
    step();
    en_t4 = 1'b0;
    chk("err_req", t_cyc, 1);
    err = 1'b1;
    step();
    err = 1'b0;
    chk("err_done", {t_completed, t_fault, t_cause}, 4'b1110);
    chk("err_cyc", t_cyc, 0);
    chk("err_rdata", t_rdata, 0);
    step();
    drive_req(1'b0, 32'hb000_0026, 32'h0, 2'b01, 1'b1);
    en_t4 = 1'b1;
    step();
    en_t4 = 1'b0;
    chk("good_sel", t_sel, 4'b1100);
    ack = 1'b1; wb_rd = 32'h9abc_0000;
    step();
    ack = 1'b0;
    chk("good_done", {t_completed, t_fault}, 2'b10);
    chk("good_rdata", t_rdata, 32'hffff_9abc);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
